// File: rtl/mc_req_queue.sv
// ---------------------------------------------------------------------------
// mc_req_queue
//   Front end of the DDR5 memory controller. A single staging slot accepts a
//   timestamped CPU request and holds it until the free-running CPU cycle
//   counter reaches the request timestamp. The request is then decoded into
//   DDR5 address fields and pushed into an in-order FIFO that the DRAM command
//   scheduler drains from the head.
//
// Ports
//   cpu_clk, rst_n          clock (rising edge) / async active-low reset
//   in_valid, in_ready      request handshake; accepted when both are high
//   in_time/core/type/addr  request fields, sampled only on accept
//   out_valid, out_ready    head handshake; popped when both are high
//   out_time/core/type      head request fields
//   out_row/col/ba/bg/ch/bsel  decoded DDR5 fields of the head entry
//   count, full             FIFO occupancy / occupancy == DEPTH
//   cycle_cnt               free-running CPU cycle counter
//   err_type                one-cycle pulse after an illegal-type accept
// ---------------------------------------------------------------------------
module mc_req_queue #(
  parameter int DEPTH  = 16,
  parameter int TIME_W = 64,
  parameter int CORE_W = 4,
  parameter int ADDR_W = 34
) (
  input  logic                       cpu_clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TIME_W-1:0]          in_time,
  input  logic [CORE_W-1:0]          in_core,
  input  logic [1:0]                 in_type,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TIME_W-1:0]          out_time,
  output logic [CORE_W-1:0]          out_core,
  output logic [1:0]                 out_type,
  output logic [15:0]                out_row,
  output logic [9:0]                 out_col,
  output logic [1:0]                 out_ba,
  output logic [2:0]                 out_bg,
  output logic                       out_ch,
  output logic [1:0]                 out_bsel,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic [TIME_W-1:0]          cycle_cnt,
  output logic                       err_type
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  // Decoded request as stored in the FIFO.
  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [CORE_W-1:0] core;
    logic [1:0]        rtype;
    logic [15:0]       row;
    logic [9:0]        col;
    logic [1:0]        ba;
    logic [2:0]        bg;
    logic              ch;
    logic [1:0]        bsel;
  } entry_t;

  state_t state, state_next;

  logic [TIME_W-1:0] stg_time;
  logic [CORE_W-1:0] stg_core;
  logic [1:0]        stg_type;
  logic [ADDR_W-1:0] stg_addr;

  entry_t            mem [DEPTH];
  entry_t            new_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic accept, due, push, pop, push_ok;

  assign accept    = in_valid & in_ready;
  assign due       = (cycle_cnt >= stg_time);
  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = (count < CNT_W'(DEPTH)) | pop;

  // ---------------- free-running cycle counter ----------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + TIME_W'(1);
  end

  // ---------------- staging FSM: state register ----------------
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // ---------------- staging FSM: next state ----------------
  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (accept && in_type != 2'd3) state_next = S_WAIT;
      S_WAIT:    if (due) state_next = push_ok ? S_IDLE : S_BLOCKED;
      S_BLOCKED: if (push_ok) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------- staging FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    push     = 1'b0;
    unique case (state)
      S_IDLE:    in_ready = 1'b1;
      S_WAIT:    push     = due & push_ok;
      S_BLOCKED: push     = push_ok;
      default:   in_ready = 1'b0;
    endcase
  end

  // Staging slot: captured only on a legal accept, so in_* are ignored
  // whenever in_ready is low.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_time <= '0;
      stg_core <= '0;
      stg_type <= '0;
      stg_addr <= '0;
    end else if (accept && in_type != 2'd3) begin
      stg_time <= in_time;
      stg_core <= in_core;
      stg_type <= in_type;
      stg_addr <= in_addr;
    end
  end

  // Illegal requests are dropped; flag them one cycle after the accept.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) err_type <= 1'b0;
    else        err_type <= accept & (in_type == 2'd3);
  end

  // ---------------- address decode at push ----------------
  always_comb begin
    new_entry.t     = stg_time;
    new_entry.core  = stg_core;
    new_entry.rtype = stg_type;
    new_entry.row   = stg_addr[33:18];
    new_entry.col   = {stg_addr[17:12], stg_addr[5:2]};
    new_entry.ba    = stg_addr[11:10];
    new_entry.bg    = stg_addr[9:7];
    new_entry.ch    = stg_addr[6];
    new_entry.bsel  = stg_addr[1:0];
  end

  // ---------------- FIFO storage ----------------
  // NOTE: the entry array has no reset; an entry is only visible after it
  // is written, and emptiness is tracked by count, not by memory contents.
  always_ff @(posedge cpu_clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // Pointers are exactly log2(DEPTH) bits and wrap on overflow.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head fields are forced to zero while empty so outputs read 0 after reset.
  assign head = mem[rd_ptr];

  always_comb begin
    out_time = '0;
    out_core = '0;
    out_type = '0;
    out_row  = '0;
    out_col  = '0;
    out_ba   = '0;
    out_bg   = '0;
    out_ch   = 1'b0;
    out_bsel = '0;
    if (out_valid) begin
      out_time = head.t;
      out_core = head.core;
      out_type = head.rtype;
      out_row  = head.row;
      out_col  = head.col;
      out_ba   = head.ba;
      out_bg   = head.bg;
      out_ch   = head.ch;
      out_bsel = head.bsel;
    end
  end

endmodule

// File: tb/tb_mc_req_queue.sv
// ---------------------------------------------------------------------------
// tb_mc_req_queue
//   Directed bench for mc_req_queue. Stimulus pushes the expected decoded
//   entry into a scoreboard queue when a request is sent; an independent
//   monitor compares the FIFO head against the scoreboard on every pop.
// ---------------------------------------------------------------------------
module tb_mc_req_queue;

  localparam int DEPTH  = 16;
  localparam int TIME_W = 64;
  localparam int CORE_W = 4;
  localparam int ADDR_W = 34;

  typedef struct {
    logic [63:0] t;
    logic [3:0]  core;
    logic [1:0]  rtype;
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  ba;
    logic [2:0]  bg;
    logic        ch;
    logic [1:0]  bsel;
  } exp_t;

  logic              cpu_clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] in_time;
  logic [CORE_W-1:0] in_core;
  logic [1:0]        in_type;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [TIME_W-1:0] out_time;
  logic [CORE_W-1:0] out_core;
  logic [1:0]        out_type;
  logic [15:0]       out_row;
  logic [9:0]        out_col;
  logic [1:0]        out_ba;
  logic [2:0]        out_bg;
  logic              out_ch;
  logic [1:0]        out_bsel;
  logic [4:0]        count;
  logic              full;
  logic [TIME_W-1:0] cycle_cnt;
  logic              err_type;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  mc_req_queue #(.DEPTH(DEPTH), .TIME_W(TIME_W), .CORE_W(CORE_W), .ADDR_W(ADDR_W)) dut (
    .cpu_clk   (cpu_clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_time   (in_time),
    .in_core   (in_core),
    .in_type   (in_type),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_time  (out_time),
    .out_core  (out_core),
    .out_type  (out_type),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_ba    (out_ba),
    .out_bg    (out_bg),
    .out_ch    (out_ch),
    .out_bsel  (out_bsel),
    .count     (count),
    .full      (full),
    .cycle_cnt (cycle_cnt),
    .err_type  (err_type)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 ns after the active edge; outputs are read there too.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic exp_t make_exp(input logic [63:0] t, input logic [3:0] c,
                                    input logic [1:0] ty, input logic [33:0] a);
    exp_t e;
    e.t     = t;
    e.core  = c;
    e.rtype = ty;
    e.row   = a[33:18];
    e.col   = {a[17:12], a[5:2]};
    e.ba    = a[11:10];
    e.bg    = a[9:7];
    e.ch    = a[6];
    e.bsel  = a[1:0];
    return e;
  endfunction

  // Wait (bounded) for the staging slot, then present the request for one edge.
  task automatic send(input logic [63:0] t, input logic [3:0] c,
                      input logic [1:0] ty, input logic [33:0] a);
    int waited = 0;
    while (!in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout_in_ready", {63'd0, in_ready}, 64'd1);
      return;
    end
    in_valid = 1'b1;
    in_time  = t;
    in_core  = c;
    in_type  = ty;
    in_addr  = a;
    tick();
    in_valid = 1'b0;
    // Garbage while not accepting must not reach the staged request.
    in_time  = '1;
    in_core  = '1;
    in_type  = 2'd1;
    in_addr  = '1;
    if (ty != 2'd3) exp_q.push_back(make_exp(t, c, ty, a));
  endtask

  task automatic pop_n(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid&ready hold
  // at the falling edge (inputs only move just after rising edges).
  always @(negedge cpu_clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("head_time", out_time, e.t);
        check("head_core", {60'd0, out_core}, {60'd0, e.core});
        check("head_type", {62'd0, out_type}, {62'd0, e.rtype});
        check("head_row",  {48'd0, out_row},  {48'd0, e.row});
        check("head_col",  {54'd0, out_col},  {54'd0, e.col});
        check("head_ba",   {62'd0, out_ba},   {62'd0, e.ba});
        check("head_bg",   {61'd0, out_bg},   {61'd0, e.bg});
        check("head_ch",   {63'd0, out_ch},   {63'd0, e.ch});
        check("head_bsel", {62'd0, out_bsel}, {62'd0, e.bsel});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    logic [33:0] a;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_time   = '0;
    in_core   = '0;
    in_type   = '0;
    in_addr   = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count",     {59'd0, count},     64'd0);
    check("rst_full",      {63'd0, full},      64'd0);
    check("rst_cycle_cnt", cycle_cnt,          64'd0);
    check("rst_err_type",  {63'd0, err_type},  64'd0);
    check("rst_out_row",   {48'd0, out_row},   64'd0);
    rst_n = 1'b1;

    // ---- 1: immediate request, all-ones address, E+1 latency ----
    send(64'd0, 4'd2, 2'd0, 34'h3_FFFF_FFFF);
    check("t1_valid_at_E", {63'd0, out_valid}, 64'd0);
    tick();
    check("t1_valid_at_E1", {63'd0, out_valid}, 64'd1);
    check("t1_count",       {59'd0, count},     64'd1);
    check("t1_row",  {48'd0, out_row},  64'h0000_0000_0000_FFFF);
    check("t1_col",  {54'd0, out_col},  64'h3FF);
    check("t1_ba",   {62'd0, out_ba},   64'd3);
    check("t1_bg",   {61'd0, out_bg},   64'd7);
    check("t1_ch",   {63'd0, out_ch},   64'd1);
    check("t1_bsel", {62'd0, out_bsel}, 64'd3);
    pop_n(1);
    check("t1_count_after_pop", {59'd0, count}, 64'd0);

    // ---- 2: future timestamp 100 accepted at cycle 5 ----
    do_reset();
    n = 0;
    while (cycle_cnt != 64'd5 && n < 50) begin
      tick();
      n++;
    end
    check("t2_start_cycle", cycle_cnt, 64'd5);
    send(64'd100, 4'd7, 2'd2, 34'h1_2345_6789);
    bad = 0;
    n = 0;
    while (cycle_cnt <= 64'd100 && n < 200) begin
      if (in_ready || out_valid) bad++;
      tick();
      n++;
    end
    check("t2_held_until_due", bad, 0);
    check("t2_cycle_after_push", cycle_cnt, 64'd101);
    check("t2_valid",   {63'd0, out_valid}, 64'd1);
    check("t2_ready",   {63'd0, in_ready},  64'd1);
    pop_n(1);

    // ---- 3: fill to 16, 17th blocked, pop lets it in same edge ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      a = 34'h2_A5A5_0000 + 34'(i) * 34'h0_0004_1235;
      send(64'(i), 4'(i), 2'(i % 3), a);
      if (i == 15) tick();
    end
    check("t3_full",  {63'd0, full},  64'd1);
    check("t3_count", {59'd0, count}, 64'd16);
    tick();
    tick();
    tick();
    check("t3_blocked_ready", {63'd0, in_ready}, 64'd0);
    check("t3_blocked_count", {59'd0, count},    64'd16);
    pop_n(1);
    check("t3_count_after_pop", {59'd0, count},    64'd16);
    check("t3_full_after_pop",  {63'd0, full},     64'd1);
    check("t3_ready_after_pop", {63'd0, in_ready}, 64'd1);
    pop_n(16);
    check("t3_drained", {59'd0, count}, 64'd0);

    // ---- 4: illegal type ----
    send(64'd0, 4'd1, 2'd1, 34'h0_0000_1040);
    tick();
    check("t4_pre_count", {59'd0, count}, 64'd1);
    send(64'd0, 4'd3, 2'd3, 34'h1_1111_1111);
    check("t4_err_pulse", {63'd0, err_type}, 64'd1);
    check("t4_ready",     {63'd0, in_ready}, 64'd1);
    tick();
    check("t4_err_clear", {63'd0, err_type}, 64'd0);
    check("t4_count",     {59'd0, count},    64'd1);
    pop_n(1);

    // ---- 5: ordering, then push/pop pairs through pointer wrap ----
    send(64'd10, 4'hA, 2'd0, 34'h0_1234_5678);
    send(64'd11, 4'hB, 2'd1, 34'h2_8765_4321);
    send(64'd12, 4'hC, 2'd2, 34'h1_5555_AAAA);
    tick();
    check("t5_count_abc", {59'd0, count}, 64'd3);
    pop_n(3);
    send(64'd1, 4'd1, 2'd0, 34'h0_0000_0044);
    send(64'd2, 4'd2, 2'd1, 34'h0_0000_0088);
    tick();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      a = 34'h3_0F0F_0000 ^ (34'(i) * 34'h0_0102_0305);
      send(64'(i + 3), 4'(i), 2'(i % 3), a);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (count != 5'd2) bad++;
    end
    check("t5_count_constant", bad, 0);
    pop_n(2);
    check("t5_drained", {59'd0, count}, 64'd0);

    // ---- 6: reset while WAIT with 5 entries queued ----
    for (int i = 0; i < 5; i++) send(64'd0, 4'(i), 2'd0, 34'(i) << 6);
    tick();
    send(64'hFFFF_FFFF, 4'd9, 2'd1, 34'h0_DEAD_BEEF);
    void'(exp_q.pop_back());
    tick();
    check("t6_pre_count", {59'd0, count},    64'd5);
    check("t6_pre_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("t6_count",     {59'd0, count},     64'd0);
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_in_ready",  {63'd0, in_ready},  64'd1);
    check("t6_cycle_cnt", cycle_cnt,          64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    send(64'd0, 4'd5, 2'd2, 34'h1_0000_0003);
    tick();
    check("t6_post_count", {59'd0, count}, 64'd1);
    pop_n(1);
    tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
